// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection, PC / IF-ID enables, ID/EX bubble insertion
// and the mult/div busy counter for the 5-stage MIPS core.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int          MULT_LAT = 5,
    parameter int          DIV_LAT  = 10,
    parameter int          CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        lu_hazard,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    output logic [31:0] next_pc,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        flush_idex,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_next;
    logic [31:0]      stall_cnt;
    logic             stall;

    // Busy flag is a decode of the registered counter, so it never depends
    // on this cycle's md_start.
    assign md_busy      = (md_cnt != '0);
    assign stall_cycles = stall_cnt;

    // A HI/LO consumer in ID must wait while the unit works, including the
    // cycle its producer is issued.
    assign stall = lu_hazard | (md_use & (md_busy | md_start));

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state logic: any md_start (re)loads the latency; otherwise count
    // down and drop back to IDLE as the counter hits zero.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_next  = BUSY;
                    md_cnt_next = md_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (md_start) begin
                    md_cnt_next = md_is_div ? DIV_LOAD : MULT_LOAD;
                end else if (md_cnt > CNT_ONE) begin
                    md_cnt_next = md_cnt - CNT_ONE;
                end else begin
                    md_cnt_next = '0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                md_cnt_next = '0;
            end
        endcase
    end

    // Fetch outputs: a stall freezes PC and IF/ID and bubbles ID/EX; a
    // redirect seen during a stall is dropped because ID re-presents it.
    // The delay-slot instruction is never squashed.
    always_comb begin
        next_pc    = pc + 32'd4;
        en_pc      = 1'b1;
        en_ifid    = 1'b1;
        flush_idex = 1'b0;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (stall) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end
    end

    // Stalled-cycle counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFFFFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
